aes_stream_packer: RTL and testbench

//  Streaming front/back end for the combinational AES cipher core. Accepts plaintext as
//  32-bit words on a valid/ready port, packs four words into a 128-bit block, and holds

---
 rtl/aes_stream_if.sv | 25 ++
 rtl/aes_stream_packer.sv | 113 +++++++++++
 tb/tb_aes_stream_packer.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_stream_if.sv
// Plaintext/ciphertext stream bundle plus the key write port of the AES stream packer.
// Handshake: a word moves on a rising edge where valid && ready; valid is never retracted until that edge.
interface aes_stream_if #(
  parameter int NK = 4
);
  logic              key_we;
  logic [NK*32-1:0]  key_in;
  logic              key_ready;
  logic              s_valid;
  logic              s_ready;
  logic [31:0]       s_data;
  logic              m_valid;
  logic              m_ready;
  logic [31:0]       m_data;

  modport slave (
    input  key_we, key_in, s_valid, s_data, m_ready,
    output key_ready, s_ready, m_valid, m_data
  );

  modport master (
    output key_we, key_in, s_valid, s_data, m_ready,
    input  key_ready, s_ready, m_valid, m_data
  );
endinterface

// File: rtl/aes_stream_packer.sv
// Packs four plaintext words into a block for a combinational AES core, waits SETTLE cycles,
// captures the ciphertext and streams it back out as four words. One block in flight.
module aes_stream_packer #(
  parameter int NK     = 4,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_stream_if.slave       bus,
  output logic [127:0]      cipher_in,
  output logic [NK*32-1:0]  cipher_key,
  input  logic [127:0]      cipher_out,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t            state;
  state_t            state_next;
  logic [1:0]        word_cnt;
  logic [7:0]        wait_cnt;
  logic [127:0]      in_reg;
  logic [127:0]      out_reg;
  logic [NK*32-1:0]  key_reg;
  logic              s_fire;
  logic              m_fire;
  logic              key_fire;
  logic              wait_done;

  // Key only opens between blocks so it can never change under a partial or in-flight block.
  always_comb begin
    bus.s_ready   = (state == ST_FILL);
    bus.m_valid   = (state == ST_DRAIN);
    bus.key_ready = (state == ST_FILL) && (word_cnt == 2'd0);
    busy          = (state != ST_FILL);
    dbg_state     = state;
    cipher_in     = in_reg;
    cipher_key    = key_reg;
    s_fire        = bus.s_valid && bus.s_ready;
    m_fire        = bus.m_valid && bus.m_ready;
    key_fire      = bus.key_we && bus.key_ready;
    wait_done     = (wait_cnt == SETTLE_LAST);
    case (word_cnt)
      2'd0:    bus.m_data = out_reg[127:96];
      2'd1:    bus.m_data = out_reg[95:64];
      2'd2:    bus.m_data = out_reg[63:32];
      default: bus.m_data = out_reg[31:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FILL;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FILL:  if (s_fire && word_cnt == 2'd3) state_next = ST_WAIT;
      ST_WAIT:  if (wait_done) state_next = ST_DRAIN;
      ST_DRAIN: if (m_fire && word_cnt == 2'd3) state_next = ST_FILL;
      default:  state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= 2'd0;
      wait_cnt <= 8'd0;
      in_reg   <= '0;
      out_reg  <= '0;
      key_reg  <= '0;
    end else begin
      if (key_fire) key_reg <= bus.key_in;
      case (state)
        ST_FILL: begin
          if (s_fire) begin
            case (word_cnt)
              2'd0:    in_reg[127:96] <= bus.s_data;
              2'd1:    in_reg[95:64]  <= bus.s_data;
              2'd2:    in_reg[63:32]  <= bus.s_data;
              default: in_reg[31:0]   <= bus.s_data;
            endcase
            // The 2-bit counter wraps 3->0 exactly as the block leaves FILL.
            word_cnt <= word_cnt + 2'd1;
            if (word_cnt == 2'd3) wait_cnt <= 8'd0;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (wait_done) begin
            out_reg  <= cipher_out;
            word_cnt <= 2'd0;
          end
        end
        ST_DRAIN: begin
          if (m_fire) word_cnt <= word_cnt + 2'd1;
        end
        default: begin
          word_cnt <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_stream_packer.sv
// Bench for aes_stream_packer around a behavioural AES-128 core, checked against FIPS-197 vectors.
module tb_aes_stream_packer;
  localparam int NK     = 4;
  localparam int SETTLE = 2;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  aes_stream_if #(.NK(NK)) bus ();
  logic [127:0]     cipher_in;
  logic [NK*32-1:0] cipher_key;
  logic [127:0]     cipher_out;
  logic             busy;
  logic [1:0]       dbg_state;

  aes_stream_packer #(.NK(NK), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cipher_in  (cipher_in),
    .cipher_key (cipher_key),
    .cipher_out (cipher_out),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- behavioural AES-128 core ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, b;
    r = 8'h01; b = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, b);
      b = gmul(b, b);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   st [16];
    logic [7:0]   t  [16];
    logic [31:0]  w  [44];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] ct;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8];
    for (int rnd = 0; rnd <= 10; rnd++) begin
      if (rnd > 0) begin
        for (int i = 0; i < 16; i++) st[i] = sbox(st[i]);
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) t[r+4*c] = st[r+4*((c+r)%4)];
        for (int i = 0; i < 16; i++) st[i] = t[i];
        if (rnd < 10) begin
          for (int c = 0; c < 4; c++) begin
            a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
            st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
          end
        end
      end
      for (int c = 0; c < 4; c++) begin
        tmp = w[4*rnd+c];
        for (int r = 0; r < 4; r++) st[r+4*c] = st[r+4*c] ^ tmp[31-8*r -: 8];
      end
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = st[i];
    return ct;
  endfunction

  assign cipher_out = aes128(cipher_in, cipher_key);

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          mv_rise_q[$];
  int          tests = 0;
  int          fails = 0;
  int          pop_count = 0;
  int          last_acc = 0;
  bit          bp_mode = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor: drives m_ready, pops and compares ----------------
  initial begin : monitor
    bit          stalled;
    bit          prev_mvalid;
    logic [31:0] stall_data;
    logic [31:0] e;
    stalled = 1'b0; prev_mvalid = 1'b0; stall_data = '0;
    bus.m_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
        prev_mvalid = 1'b0;
        continue;
      end
      tests++;
      if (busy !== !bus.s_ready) begin
        fails++;
        $display("FAIL busy_vs_s_ready: busy=%b s_ready=%b", busy, bus.s_ready);
      end
      if (stalled) begin
        tests++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== stall_data) begin
          fails++;
          $display("FAIL stall_hold: m_valid=%b m_data=%h expected 1/%h", bus.m_valid, bus.m_data, stall_data);
        end
      end
      if (bus.m_valid && !prev_mvalid) mv_rise_q.push_back(cyc + 1);
      prev_mvalid = bus.m_valid;
      bus.m_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.m_valid && bus.m_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_word: got %h with no word expected", bus.m_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.m_data !== e) begin
            fails++;
            $display("FAIL m_data: got %h expected %h", bus.m_data, e);
          end
        end
        pop_count++;
        stalled = 1'b0;
      end else if (bus.m_valid) begin
        stalled = 1'b1;
        stall_data = bus.m_data;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic send_word(input logic [31:0] w);
    int n;
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    n = 0;
    while (!bus.s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL s_ready_timeout: s_ready=0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    @(negedge clk);
    last_acc = cyc;
    bus.s_valid = 1'b0;
  endtask

  task automatic push_block(input logic [127:0] ct);
    for (int i = 0; i < 4; i++) exp_q.push_back(ct[127-32*i -: 32]);
  endtask

  task automatic send_block(input logic [127:0] pt, input logic [127:0] ct, input int gapmax);
    push_block(ct);
    for (int i = 0; i < 4; i++) begin
      send_word(pt[127-32*i -: 32]);
      if (i < 3) repeat ($urandom_range(0, gapmax)) @(negedge clk);
    end
  endtask

  task automatic write_key(input logic [127:0] k);
    bus.key_in = k;
    bus.key_we = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.key_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 300) begin
      fails++;
      $display("FAIL idle_timeout: %0d words still expected after %0d cycles", exp_q.size(), n);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int n;
    int base;
    bus.key_we = 1'b0; bus.key_in = '0; bus.s_valid = 1'b0; bus.s_data = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_s_ready",    128'(bus.s_ready),   128'h1);
    check("rst_m_valid",    128'(bus.m_valid),   128'h0);
    check("rst_busy",       128'(busy),          128'h0);
    check("rst_key_ready",  128'(bus.key_ready), 128'h1);
    check("rst_cipher_in",  cipher_in,           128'h0);
    check("rst_cipher_key", cipher_key,          128'h0);
    check("rst_m_data",     128'(bus.m_data),    128'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // C.1 vector back-to-back, latency from last accept to first m_valid edge
    write_key(KEY_C1);
    check("key_write_c1", cipher_key, KEY_C1);
    mv_rise_q.delete();
    send_block(PT_C1, CT_C1, 0);
    check("cipher_in_packed", cipher_in, PT_C1);
    wait_idle();
    check("latency_count", 128'(mv_rise_q.size()), 128'd1);
    if (mv_rise_q.size() > 0) check("latency", 128'(mv_rise_q[0] - last_acc), 128'd3);

    // random output backpressure
    bp_mode = 1'b1;
    send_block(PT_C1, CT_C1, 0);
    wait_idle();
    bp_mode = 1'b0;

    // key write mid-fill is ignored
    push_block(CT_C1);
    send_word(PT_C1[127:96]);
    send_word(PT_C1[95:64]);
    check("key_ready_midfill", 128'(bus.key_ready), 128'h0);
    write_key(KEY_B);
    check("key_locked", cipher_key, KEY_C1);
    send_word(PT_C1[63:32]);
    send_word(PT_C1[31:0]);
    wait_idle();

    // key write together with first word in idle FILL
    push_block(CT_B);
    bus.key_in = KEY_B;
    bus.key_we = 1'b1;
    send_word(PT_B[127:96]);
    bus.key_we = 1'b0;
    check("key_with_word", cipher_key, KEY_B);
    send_word(PT_B[95:64]);
    send_word(PT_B[63:32]);
    send_word(PT_B[31:0]);
    wait_idle();

    // gapped input
    send_block(PT_B, CT_B, 3);
    wait_idle();

    // three blocks back to back, 10-cycle period
    mv_rise_q.delete();
    for (int b = 0; b < 3; b++) send_block(PT_B, CT_B, 0);
    wait_idle();
    check("b2b_blocks", 128'(mv_rise_q.size()), 128'd3);
    if (mv_rise_q.size() == 3) begin
      check("period_1", 128'(mv_rise_q[1] - mv_rise_q[0]), 128'd10);
      check("period_2", 128'(mv_rise_q[2] - mv_rise_q[1]), 128'd10);
    end

    // reset in the middle of DRAIN after two words out
    base = pop_count;
    send_block(PT_B, CT_B, 0);
    n = 0;
    while (pop_count != base + 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_reach", 128'(pop_count - base), 128'd2);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_m_valid",    128'(bus.m_valid), 128'h0);
    check("mid_rst_s_ready",    128'(bus.s_ready), 128'h1);
    check("mid_rst_cipher_key", cipher_key,        128'h0);
    check("mid_rst_busy",       128'(busy),        128'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    write_key(KEY_C1);
    send_block(PT_C1, CT_C1, 1);
    wait_idle();
    check("final_queue_empty", 128'(exp_q.size()), 128'd0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
